// File: rtl/apb_cmd_master.sv
// ---------------------------------------------------------------------------
// apb_cmd_master
//   Turns a simple valid/ready command stream into single APB transfers and
//   returns one response per command. Only one transfer is in flight at a
//   time: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
//
// Parameters
//   ADDR_WIDTH  APB address width
//   DATA_WIDTH  APB data width
//   TIMEOUT     max ACCESS cycles without PREADY before the transfer is
//               aborted; 0 disables the timeout
//
// Ports
//   PCLK, PRESETn             clock, asynchronous active-low reset
//   cmd_valid/cmd_ready       command handshake (cmd_ready high only in IDLE)
//   cmd_write/addr/wdata      command payload
//   rsp_valid/rsp_ready       response handshake
//   rsp_rdata/err/timeout     response payload (rdata is 0 for writes/aborts)
//   PSEL/PENABLE/PWRITE/
//   PADDR/PWDATA              APB requester outputs
//   PRDATA/PREADY/PSLVERR     APB completer inputs
// ---------------------------------------------------------------------------
module apb_cmd_master #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  // A disabled timeout still gets a 1-bit counter so no zero-width vector
  // is ever declared.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        cnt_inc;
  logic                    timeout_hit;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= S_IDLE;
      cmd_ready_q   <= 1'b1;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;

    // Saturating increment; the abort fires on the edge the count would
    // reach TIMEOUT, so ACCESS never lasts longer than TIMEOUT cycles.
    cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    timeout_hit = (TIMEOUT != 0) && (cnt_inc == CNT_LIMIT);

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        // PREADY is checked first so a completion on the timeout edge wins.
        if (PREADY) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = S_RESP;
        end else begin
          cnt_d = cnt_inc;
          if (timeout_hit) begin
            psel_d        = 1'b0;
            penable_d     = 1'b0;
            rsp_rdata_d   = '0;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_valid_d   = 1'b1;
            state_d       = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // cmd_ready is a flop that mirrors "next state is IDLE", so it never
    // depends combinationally on cmd_valid.
    cmd_ready_d = (state_d == S_IDLE);
  end

  assign cmd_ready   = cmd_ready_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Testbench for apb_cmd_master (TIMEOUT set to 4 so aborts are reachable).
module tb_apb_cmd_master;

  localparam int AW = 13;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          PCLK = 1'b0;
  logic          PRESETn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA = '0;
  logic          PREADY = 1'b0;
  logic          PSLVERR = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  // Observations filled by the transfer driver.
  bit            obs_hang;
  int            obs_wait_accept;
  int            obs_psel, obs_pen, obs_lat;
  logic [DW-1:0] obs_rdata;
  logic          obs_err, obs_to;
  bit            obs_seen, obs_apb_ok, obs_rsp_stable, obs_busy_ready;
  logic          obs_rv_after, obs_idle_after;

  apb_cmd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: a completer that holds PREADY low for 'waits' ACCESS cycles.
  // With timeout T the transfer is aborted once T ACCESS cycles pass without
  // PREADY; a PREADY on the T-th cycle still completes normally.
  function automatic void model(input bit wr, input int waits, input logic [DW-1:0] rd,
                                input bit serr, output int e_acc, output logic [DW-1:0] e_rdata,
                                output bit e_err, output bit e_to);
    if (TO != 0 && waits >= TO) begin
      e_acc = TO; e_rdata = '0; e_err = 1'b1; e_to = 1'b1;
    end else begin
      e_acc = waits + 1; e_rdata = wr ? '0 : rd; e_err = serr; e_to = 1'b0;
    end
  endfunction

  // Runs one command to completion; caller is positioned just after a negedge.
  task automatic do_xfer(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input int waits, input logic [DW-1:0] rd, input bit serr,
                         input int rsp_hold, input bit keep_valid);
    int lat; int acc; int hold; bit done;
    obs_hang = 0; obs_wait_accept = 0; obs_psel = 0; obs_pen = 0; obs_lat = 0;
    obs_rdata = 'x; obs_err = 1'bx; obs_to = 1'bx; obs_seen = 0;
    obs_apb_ok = 1; obs_rsp_stable = 1; obs_busy_ready = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    while (cmd_ready !== 1'b1) begin
      @(negedge PCLK);
      obs_wait_accept++;
      if (obs_wait_accept > 20) begin obs_hang = 1; cmd_valid = 1'b0; return; end
    end
    lat = 0; acc = 0; hold = 0; done = 0;
    while (!done) begin
      @(negedge PCLK);
      lat++;
      if (keep_valid) begin
        cmd_valid = 1'b1; cmd_write = 1'($urandom_range(1, 0));
        cmd_addr = AW'($urandom); cmd_wdata = $urandom;
      end else begin
        cmd_valid = 1'b0;
      end
      if (cmd_ready !== 1'b0) obs_busy_ready = 1;
      if (PSEL === 1'b1) begin
        obs_psel++;
        if (PADDR !== addr || PWRITE !== wr || PWDATA !== wd) obs_apb_ok = 0;
      end
      if (PENABLE === 1'b1) obs_pen++;
      if (PSEL === 1'b1 && PENABLE === 1'b1) begin
        acc++;
        if (acc > waits) begin
          PREADY = 1'b1; PRDATA = rd; PSLVERR = serr;
        end else begin
          PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom_range(1, 0));
        end
      end else begin
        PREADY = 1'($urandom_range(1, 0)); PRDATA = $urandom; PSLVERR = 1'($urandom_range(1, 0));
      end
      if (rsp_valid === 1'b1) begin
        if (!obs_seen) begin
          obs_seen = 1; obs_lat = lat;
          obs_rdata = rsp_rdata; obs_err = rsp_err; obs_to = rsp_timeout;
        end else if (rsp_rdata !== obs_rdata || rsp_err !== obs_err || rsp_timeout !== obs_to) begin
          obs_rsp_stable = 0;
        end
        if (hold < rsp_hold) begin rsp_ready = 1'b0; hold++; end
        else begin rsp_ready = 1'b1; done = 1; end
      end
      if (lat > 100) begin obs_hang = 1; done = 1; end
    end
    @(negedge PCLK);
    rsp_ready = 1'b0; PREADY = 1'b0;
    obs_rv_after = rsp_valid; obs_idle_after = cmd_ready;
    if (!keep_valid) cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    PRESETn = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 13'h1ff; cmd_wdata = 32'hffff_ffff;
    PREADY = 1'b1; PRDATA = 32'hffff_ffff; PSLVERR = 1'b1; rsp_ready = 1'b0;
    repeat (3) @(negedge PCLK);
    tests_run++;
    if ({PSEL, PENABLE, PWRITE} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_ctrl: PSEL/PENABLE/PWRITE=%b want 000", {PSEL, PENABLE, PWRITE});
    end
    tests_run++;
    if (PADDR !== '0 || PWDATA !== '0) begin
      tests_failed++; $display("FAIL reset_addr_data: PADDR=%h PWDATA=%h want 0", PADDR, PWDATA);
    end
    tests_run++;
    if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b000 || rsp_rdata !== '0) begin
      tests_failed++;
      $display("FAIL reset_rsp: valid/err/to=%b rdata=%h want 000/0", {rsp_valid, rsp_err, rsp_timeout}, rsp_rdata);
    end
    cmd_valid = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0;
    PRESETn = 1'b1;
    @(negedge PCLK);
    tests_run++;
    if (cmd_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
    end
    $display("[TB] reset done");
  endtask

  task automatic test_write_zero_wait();
    do_xfer(1'b1, 13'h010, 32'hDEADBEEF, 0, 32'hA5A5_A5A5, 1'b0, 0, 1'b0);
    tests_run++;
    if (obs_hang) begin tests_failed++; $display("FAIL wr0_hang: got hang want completion"); end
    tests_run++;
    if (obs_psel !== 2 || obs_pen !== 1) begin
      tests_failed++; $display("FAIL wr0_psel_pen: got %0d/%0d want 2/1", obs_psel, obs_pen);
    end
    tests_run++;
    if (obs_lat !== 3) begin tests_failed++; $display("FAIL wr0_latency: got %0d want 3", obs_lat); end
    tests_run++;
    if (obs_rdata !== '0 || obs_err !== 1'b0 || obs_to !== 1'b0) begin
      tests_failed++; $display("FAIL wr0_rsp: rdata=%h err=%b to=%b want 0/0/0", obs_rdata, obs_err, obs_to);
    end
    tests_run++;
    if (!obs_apb_ok) begin tests_failed++; $display("FAIL wr0_apb_fields: got mismatch want addr/data/write stable"); end
    tests_run++;
    if (obs_rv_after !== 1'b0 || obs_idle_after !== 1'b1) begin
      tests_failed++; $display("FAIL wr0_return_idle: rsp_valid=%b cmd_ready=%b want 0/1", obs_rv_after, obs_idle_after);
    end
    $display("[TB] write 0x010 <= DEADBEEF lat=%0d", obs_lat);
  endtask

  task automatic test_read_wait();
    do_xfer(1'b0, 13'h004, 32'h0, 2, 32'h12345678, 1'b0, 0, 1'b0);
    tests_run++;
    if (obs_pen !== 3) begin tests_failed++; $display("FAIL rd2_access_cycles: got %0d want 3", obs_pen); end
    tests_run++;
    if (obs_rdata !== 32'h12345678 || obs_err !== 1'b0 || obs_to !== 1'b0) begin
      tests_failed++; $display("FAIL rd2_rsp: rdata=%h err=%b to=%b want 12345678/0/0", obs_rdata, obs_err, obs_to);
    end
    tests_run++;
    if (!obs_apb_ok) begin tests_failed++; $display("FAIL rd2_paddr_stable: got unstable want stable"); end
    $display("[TB] read 0x004 waits=2 rdata=%h", obs_rdata);
  endtask

  task automatic test_slverr();
    do_xfer(1'b0, 13'h0A0, 32'h1, 1, 32'hCAFE_F00D, 1'b1, 0, 1'b0);
    tests_run++;
    if (obs_err !== 1'b1 || obs_to !== 1'b0 || obs_rdata !== 32'hCAFE_F00D) begin
      tests_failed++; $display("FAIL slverr_rsp: err=%b to=%b rdata=%h want 1/0/cafef00d", obs_err, obs_to, obs_rdata);
    end
    $display("[TB] read with PSLVERR err=%b to=%b", obs_err, obs_to);
  endtask

  task automatic test_timeout();
    do_xfer(1'b0, 13'h1F0, 32'h2, 50, 32'h1111_2222, 1'b0, 0, 1'b0);
    tests_run++;
    if (obs_pen !== TO || obs_lat !== TO + 2) begin
      tests_failed++; $display("FAIL timeout_cycles: access=%0d lat=%0d want %0d/%0d", obs_pen, obs_lat, TO, TO + 2);
    end
    tests_run++;
    if (obs_err !== 1'b1 || obs_to !== 1'b1 || obs_rdata !== '0) begin
      tests_failed++; $display("FAIL timeout_rsp: err=%b to=%b rdata=%h want 1/1/0", obs_err, obs_to, obs_rdata);
    end
    $display("[TB] timeout after %0d access cycles", obs_pen);
  endtask

  task automatic test_timeout_race();
    do_xfer(1'b0, 13'h1F4, 32'h3, TO - 1, 32'h3333_4444, 1'b0, 0, 1'b0);
    tests_run++;
    if (obs_pen !== TO || obs_to !== 1'b0 || obs_err !== 1'b0 || obs_rdata !== 32'h3333_4444) begin
      tests_failed++;
      $display("FAIL timeout_race: access=%0d to=%b err=%b rdata=%h want %0d/0/0/33334444", obs_pen, obs_to, obs_err, obs_rdata, TO);
    end
    $display("[TB] PREADY on last allowed cycle to=%b", obs_to);
  endtask

  task automatic test_back_to_back();
    do_xfer(1'b0, 13'h020, 32'h5, 0, 32'h5555_6666, 1'b0, 5, 1'b1);
    tests_run++;
    if (!obs_rsp_stable) begin tests_failed++; $display("FAIL b2b_rsp_stable: got changing want stable"); end
    tests_run++;
    if (obs_busy_ready) begin tests_failed++; $display("FAIL b2b_cmd_ready_busy: got 1 while busy want 0"); end
    tests_run++;
    if (obs_rdata !== 32'h5555_6666 || obs_apb_ok !== 1'b1) begin
      tests_failed++; $display("FAIL b2b_first: rdata=%h apb_ok=%b want 55556666/1", obs_rdata, obs_apb_ok);
    end
    do_xfer(1'b1, 13'h024, 32'h7777_8888, 1, 32'h0, 1'b0, 0, 1'b0);
    tests_run++;
    if (obs_wait_accept !== 0) begin
      tests_failed++; $display("FAIL b2b_accept_delay: got %0d extra cycles want 0", obs_wait_accept);
    end
    tests_run++;
    if (obs_apb_ok !== 1'b1 || obs_err !== 1'b0 || obs_rdata !== '0) begin
      tests_failed++; $display("FAIL b2b_second: apb_ok=%b err=%b rdata=%h want 1/0/0", obs_apb_ok, obs_err, obs_rdata);
    end
    $display("[TB] back-to-back second accept delay=%0d", obs_wait_accept);
  endtask

  task automatic test_reset_mid();
    int n; bit saw_rsp;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 13'h0C0; cmd_wdata = 32'h0;
    PREADY = 1'b0;
    n = 0;
    do begin
      @(negedge PCLK); n++;
      cmd_valid = 1'b0; PREADY = 1'b0;
    end while (!(PSEL === 1'b1 && PENABLE === 1'b1) && n < 10);
    tests_run++;
    if (n >= 10) begin tests_failed++; $display("FAIL rstmid_reach_access: got no ACCESS want ACCESS"); end
    #1 PRESETn = 1'b0;
    #1;
    tests_run++;
    if (PSEL !== 1'b0 || PENABLE !== 1'b0) begin
      tests_failed++; $display("FAIL rstmid_async: PSEL=%b PENABLE=%b want 0/0", PSEL, PENABLE);
    end
    @(negedge PCLK);
    PRESETn = 1'b1; PREADY = 1'b1;
    saw_rsp = 0;
    repeat (6) begin
      @(negedge PCLK);
      if (rsp_valid !== 1'b0) saw_rsp = 1;
    end
    PREADY = 1'b0;
    tests_run++;
    if (saw_rsp) begin tests_failed++; $display("FAIL rstmid_no_rsp: got rsp_valid want none"); end
    do_xfer(1'b0, 13'h0C4, 32'h9, 1, 32'h9999_AAAA, 1'b0, 1, 1'b0);
    tests_run++;
    if (obs_hang || obs_rdata !== 32'h9999_AAAA || obs_err !== 1'b0 || obs_lat !== 4) begin
      tests_failed++; $display("FAIL rstmid_next: rdata=%h err=%b lat=%0d want 9999aaaa/0/4", obs_rdata, obs_err, obs_lat);
    end
    $display("[TB] reset during ACCESS, next read rdata=%h", obs_rdata);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      bit wr; bit se; int w; int h; int e_acc; bit e_err; bit e_to;
      logic [AW-1:0] a; logic [DW-1:0] wd; logic [DW-1:0] rd; logic [DW-1:0] e_rdata;
      wr = 1'($urandom_range(1, 0)); se = 1'($urandom_range(1, 0));
      a = AW'($urandom); wd = $urandom; rd = $urandom;
      w = $urandom_range(6, 0); h = $urandom_range(3, 0);
      model(wr, w, rd, se, e_acc, e_rdata, e_err, e_to);
      do_xfer(wr, a, wd, w, rd, se, h, 1'b0);
      tests_run++;
      if (obs_hang || obs_lat !== e_acc + 2 || obs_pen !== e_acc || obs_psel !== e_acc + 1) begin
        tests_failed++;
        $display("FAIL rnd%0d_timing: lat=%0d pen=%0d psel=%0d want %0d/%0d/%0d", n, obs_lat, obs_pen, obs_psel, e_acc + 2, e_acc, e_acc + 1);
      end
      tests_run++;
      if (obs_rdata !== e_rdata || obs_err !== e_err || obs_to !== e_to) begin
        tests_failed++;
        $display("FAIL rnd%0d_rsp: rdata=%h err=%b to=%b want %h/%b/%b", n, obs_rdata, obs_err, obs_to, e_rdata, e_err, e_to);
      end
      tests_run++;
      if (!obs_apb_ok || !obs_rsp_stable || obs_busy_ready || obs_rv_after !== 1'b0 || obs_idle_after !== 1'b1) begin
        tests_failed++;
        $display("FAIL rnd%0d_protocol: apb_ok=%b stable=%b busy_rdy=%b rv_after=%b idle=%b want 1/1/0/0/1",
                 n, obs_apb_ok, obs_rsp_stable, obs_busy_ready, obs_rv_after, obs_idle_after);
      end
      $display("[TB] txn %0d %s addr=%h waits=%0d hold=%0d -> rdata=%h err=%b to=%b",
               n, wr ? "WR" : "RD", a, w, h, obs_rdata, obs_err, obs_to);
    end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_timeout_race();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/apb_cmd_master.md
APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 13, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, max ACCESS cycles without PREADY; 0 disables timeout.
REQ-004 PCLK  in  1  single clock, all logic on rising edge.
REQ-005 PRESETn  in  1  reset, asynchronous, active-low.
REQ-006 cmd_valid  in  1  command present.
REQ-007 cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
REQ-008 cmd_write  in  1  1 = write, 0 = read.
REQ-009 cmd_addr  in  ADDR_WIDTH  target address.
REQ-010 cmd_wdata  in  DATA_WIDTH  write data.
REQ-011 rsp_valid  out  1  response present.
REQ-012 rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
REQ-013 rsp_rdata  out  DATA_WIDTH  read data (0 for writes and timeouts).
REQ-014 rsp_err  out  1  PSLVERR or timeout.
REQ-015 rsp_timeout  out  1  transfer aborted by timeout.
REQ-016 PSEL, PENABLE, PWRITE  out  1 each  APB master control.
REQ-017 PADDR  out  ADDR_WIDTH; PWDATA  out  DATA_WIDTH  APB master address/data.
REQ-018 PRDATA  in  DATA_WIDTH; PREADY  in  1; PSLVERR  in  1  APB completer response.

Function
REQ-019 SHALL implement FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE; one transfer outstanding at most.
REQ-020 cmd_ready SHALL be 1 only in IDLE; registered outputs only, no combinational path cmd_valid->cmd_ready.
REQ-021 On accept edge: capture cmd_write/addr/wdata into PWRITE/PADDR/PWDATA, PSEL<=1, PENABLE<=0, enter SETUP.
REQ-022 SETUP lasts exactly 1 cycle; next edge PENABLE<=1, enter ACCESS, clear timeout counter.
REQ-023 PADDR, PWRITE, PWDATA, PSEL SHALL stay stable from SETUP through end of ACCESS.
REQ-024 ACCESS, edge with PREADY=1: PSEL<=0, PENABLE<=0, rsp_rdata<=(read ? PRDATA : 0), rsp_err<=PSLVERR, rsp_timeout<=0, rsp_valid<=1, enter RESP.
REQ-025 ACCESS, PREADY=0: counter increments; when counter reaches TIMEOUT (TIMEOUT!=0), abort: PSEL<=0, PENABLE<=0, rsp_rdata<=0, rsp_err<=1, rsp_timeout<=1, rsp_valid<=1, enter RESP.
REQ-026 PREADY=1 on the same edge the timeout fires SHALL win (normal completion).
REQ-027 Counter width SHALL be $clog2(TIMEOUT+1), saturating, never wraps.
REQ-028 RESP: rsp_* held stable until rsp_ready=1; on that edge rsp_valid<=0, enter IDLE.
REQ-029 Minimum latency accept->rsp_valid SHALL be 3 cycles (zero-wait completer); throughput 1 command per 4 cycles minimum.
REQ-030 PSLVERR and PRDATA SHALL be sampled only on the completing ACCESS edge.
REQ-031 cmd_valid asserted while not in IDLE SHALL be ignored until IDLE.

Reset
REQ-032 PRESETn low SHALL immediately (asynchronously) force state IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, counter=0; cmd_ready=1 after release.
REQ-033 Reset mid-transfer SHALL drop the transfer with no response generated.

Verification
REQ-034 Write addr 0x010 data 0xDEADBEEF, PREADY tied 1 -> PSEL high 2 cycles, PENABLE 1 cycle, rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
REQ-035 Read addr 0x004, completer 2 wait states returns 0x12345678 -> ACCESS 3 cycles, rsp_rdata=0x12345678, PADDR stable throughout.
REQ-036 Read with PSLVERR=1 on completion -> rsp_err=1, rsp_timeout=0.
REQ-037 TIMEOUT=4, PREADY held 0 -> abort after 4 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0; PREADY=1 on 4th cycle -> normal completion.
REQ-038 rsp_ready held 0 for 5 cycles with back-to-back cmd_valid -> rsp stable, cmd_ready=0, second command accepted one cycle after rsp_ready.
REQ-039 PRESETn asserted during ACCESS -> PSEL/PENABLE 0 same cycle, no rsp_valid, next command completes normally.
